// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve gating, miss detection, scoring, inter-point pause, winner.
// Optional PONG_AUTOSERVE_EN: SERVE also auto-advances to PLAY after PAUSE_FRAMES frame ticks.
module pong_match_ctrl #(
  parameter int unsigned SCREEN_WIDTH = 640,
  parameter int unsigned BALL_SIZE    = 10,
  parameter int unsigned MISS_MARGIN  = 2,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned PAUSE_FRAMES = 60
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        serve_btn,
  input  logic [15:0] Ball_X,
  output logic        start_game,
  output logic        ball_reset,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic [1:0]  winner,
  output logic [2:0]  game_state
);

  localparam int unsigned RIGHT_LIMIT = SCREEN_WIDTH - BALL_SIZE - MISS_MARGIN;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        serve_q, serve_d;
  logic        start_game_q, start_game_d;
  logic        ball_reset_q, ball_reset_d;
  logic [3:0]  score1_q, score1_d;
  logic [3:0]  score2_q, score2_d;
  logic [1:0]  winner_q, winner_d;
  logic [7:0]  pause_cnt_q, pause_cnt_d;

  logic        serve_rise;
  logic        left_miss;
  logic        right_miss;
  logic        pause_last;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    serve_rise   = serve_btn & ~serve_q;
    left_miss    = (Ball_X <= 16'(MISS_MARGIN)) | Ball_X[15];
    right_miss   = Ball_X >= 16'(RIGHT_LIMIT);
    pause_last   = pause_cnt_q == 8'(PAUSE_FRAMES - 1);

    state_d      = state_q;
    serve_d      = serve_btn;
    ball_reset_d = 1'b0;
    score1_d     = score1_q;
    score2_d     = score2_q;
    winner_d     = winner_q;
    pause_cnt_d  = pause_cnt_q;

    case (state_q)
      ST_IDLE: begin
        score1_d = 4'd0;
        score2_d = 4'd0;
        winner_d = 2'b00;
        if (serve_rise) begin
          state_d      = ST_SERVE;
          ball_reset_d = 1'b1;
          pause_cnt_d  = 8'd0;
        end
      end
      ST_SERVE: begin
        if (serve_rise) begin
          state_d = ST_PLAY;
`ifdef PONG_AUTOSERVE_EN
        end else if (frame_tick) begin
          if (pause_last) state_d = ST_PLAY;
          else            pause_cnt_d = pause_cnt_q + 8'd1;
`endif
        end
      end
      ST_PLAY: begin
        // Left miss wins when both edges report a miss
        if (left_miss) begin
          score2_d    = sat_inc(score2_q);
          state_d     = ST_POINT;
          pause_cnt_d = 8'd0;
        end else if (right_miss) begin
          score1_d    = sat_inc(score1_q);
          state_d     = ST_POINT;
          pause_cnt_d = 8'd0;
        end
      end
      ST_POINT: begin
        if (frame_tick) begin
          if (pause_last) begin
            if (score1_q == 4'(WIN_SCORE)) begin
              state_d  = ST_OVER;
              winner_d = 2'b01;
            end else if (score2_q == 4'(WIN_SCORE)) begin
              state_d  = ST_OVER;
              winner_d = 2'b10;
            end else begin
              state_d      = ST_SERVE;
              ball_reset_d = 1'b1;
              pause_cnt_d  = 8'd0;
            end
          end else begin
            pause_cnt_d = pause_cnt_q + 8'd1;
          end
        end
      end
      ST_OVER: begin
        if (serve_rise) begin
          state_d  = ST_IDLE;
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = 2'b00;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        score1_d    = 4'd0;
        score2_d    = 4'd0;
        winner_d    = 2'b00;
        pause_cnt_d = 8'd0;
      end
    endcase

    start_game_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      serve_q      <= 1'b0;
      start_game_q <= 1'b0;
      ball_reset_q <= 1'b0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      winner_q     <= 2'b00;
      pause_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      serve_q      <= serve_d;
      start_game_q <= start_game_d;
      ball_reset_q <= ball_reset_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
      pause_cnt_q  <= pause_cnt_d;
    end
  end

  assign start_game = start_game_q;
  assign ball_reset = ball_reset_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign winner     = winner_q;
  assign game_state = 3'(state_q);

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: match-level model compared every cycle plus directed literal checks.
module tb_pong_match_ctrl;

  localparam int WIN   = 7;
  localparam int PAUSE = 60;
  localparam int RLIM  = 640 - 10 - 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        serve_btn = 1'b0;
  logic [15:0] Ball_X = 16'd300;
  logic        start_game, ball_reset;
  logic [3:0]  score1, score2;
  logic [1:0]  winner;
  logic [2:0]  game_state;

  int n_cmp = 0;
  int n_err = 0;
  bit armed = 0;

  pong_match_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .serve_btn  (serve_btn),
    .Ball_X     (Ball_X),
    .start_game (start_game),
    .ball_reset (ball_reset),
    .score1     (score1),
    .score2     (score2),
    .winner     (winner),
    .game_state (game_state)
  );

  always #5 clock = ~clock;

  // Match model: phase 0 idle, 1 waiting for serve, 2 rally, 3 pause after a point, 4 match over
  int m_phase = 0, m_prev_phase = 0;
  int m_s1 = 0, m_s2 = 0;
  int m_ticks = 0;
  bit m_prev_btn = 0;

  always @(posedge clock or posedge reset) begin
    bit rise, lmiss, rmiss;
    if (reset) begin
      m_phase = 0; m_prev_phase = 0; m_s1 = 0; m_s2 = 0; m_ticks = 0; m_prev_btn = 0;
    end else begin
      rise  = serve_btn && !m_prev_btn;
      lmiss = (int'(Ball_X) <= 2) || (int'(Ball_X) >= 32768);
      rmiss = int'(Ball_X) >= RLIM;
      m_prev_btn   = serve_btn;
      m_prev_phase = m_phase;
      case (m_phase)
        0: if (rise) begin m_phase = 1; m_ticks = 0; end
        1: begin
          if (rise) m_phase = 2;
`ifdef PONG_AUTOSERVE_EN
          else if (frame_tick) begin
            m_ticks++;
            if (m_ticks == PAUSE) m_phase = 2;
          end
`endif
        end
        2: begin
          if (lmiss)      begin m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_phase = 3; m_ticks = 0; end
          else if (rmiss) begin m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_phase = 3; m_ticks = 0; end
        end
        3: if (frame_tick) begin
          m_ticks++;
          if (m_ticks == PAUSE) begin
            if (m_s1 == WIN || m_s2 == WIN) m_phase = 4;
            else begin m_phase = 1; m_ticks = 0; end
          end
        end
        default: if (rise) begin m_phase = 0; m_s1 = 0; m_s2 = 0; end
      endcase
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    int exp_win;
    if (armed && !reset) begin
      exp_win = (m_phase == 4) ? ((m_s1 == WIN) ? 1 : 2) : 0;
      chk("m_state",  16'(game_state), 16'(m_phase));
      chk("m_start",  16'(start_game), 16'(m_phase == 2));
      chk("m_brst",   16'(ball_reset), 16'(m_phase == 1 && m_prev_phase != 1));
      chk("m_score1", 16'(score1), 16'(m_s1));
      chk("m_score2", 16'(score2), 16'(m_s2));
      chk("m_winner", 16'(winner), 16'(exp_win));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press();
    serve_btn = 1'b1; step(1);
    serve_btn = 1'b0; step(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1; step(1);
      frame_tick = 1'b0; step(1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},  16'(game_state), 16'd0);
    chk({tag, "_start"},  16'(start_game), 16'd0);
    chk({tag, "_brst"},   16'(ball_reset), 16'd0);
    chk({tag, "_s1"},     16'(score1), 16'd0);
    chk({tag, "_s2"},     16'(score2), 16'd0);
    chk({tag, "_winner"}, 16'(winner), 16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(2);
    chk_reset_vals("rst");
    reset = 1'b0;
    armed = 1'b1;
    step(1);

    // Serve from IDLE
    serve_btn = 1'b1; step(1);
    chk("serve_state", 16'(game_state), 16'd1);
    chk("serve_brst",  16'(ball_reset), 16'd1);
    serve_btn = 1'b0; step(1);
    chk("serve_brst_once", 16'(ball_reset), 16'd0);

    // Frame ticks in SERVE with no button
    ticks(PAUSE);
`ifdef PONG_AUTOSERVE_EN
    chk("autoserve_state", 16'(game_state), 16'd2);
`else
    chk("noauto_state", 16'(game_state), 16'd1);
    serve_btn = 1'b1; step(1);
    chk("play_state", 16'(game_state), 16'd2);
    chk("play_start", 16'(start_game), 16'd1);
    serve_btn = 1'b0; step(1);
`endif

    // Ball_X = 1: left miss
    Ball_X = 16'd1; step(1);
    chk("lmiss_s2",    16'(score2), 16'd1);
    chk("lmiss_state", 16'(game_state), 16'd3);
    chk("lmiss_start", 16'(start_game), 16'd0);
    Ball_X = 16'd300;
    ticks(PAUSE - 1);
    chk("pause_hold", 16'(game_state), 16'd3);
    frame_tick = 1'b1; step(1);
    chk("pause_exit", 16'(game_state), 16'd1);
    chk("pause_brst", 16'(ball_reset), 16'd1);
    frame_tick = 1'b0; step(1);
    chk("pause_brst_once", 16'(ball_reset), 16'd0);

    // Underflowed X counts as a left miss
    press();
    Ball_X = 16'hFFFE; step(1);
    chk("uflow_s2", 16'(score2), 16'd2);
    Ball_X = 16'd300;
    ticks(PAUSE);
    press();

    // Right edge boundary: 627 is safe, 628 scores
    Ball_X = 16'd627; step(3);
    chk("edge627_state", 16'(game_state), 16'd2);
    chk("edge627_s1",    16'(score1), 16'd0);
    Ball_X = 16'd628; step(1);
    chk("edge628_s1",    16'(score1), 16'd1);
    chk("edge628_state", 16'(game_state), 16'd3);
    Ball_X = 16'd300;

    // Player 1 scores to WIN
    repeat (WIN - 1) begin
      ticks(PAUSE);
      press();
      Ball_X = 16'd640; step(1);
      Ball_X = 16'd300;
    end
    chk("p1_s1", 16'(score1), 16'(WIN));
    ticks(PAUSE);
    chk("over_state",  16'(game_state), 16'd4);
    chk("over_winner", 16'(winner), 16'd1);
    chk("over_s2",     16'(score2), 16'd2);
    serve_btn = 1'b1; step(1);
    chk("idle_state",  16'(game_state), 16'd0);
    chk("idle_s1",     16'(score1), 16'd0);
    chk("idle_s2",     16'(score2), 16'd0);
    chk("idle_winner", 16'(winner), 16'd0);
    serve_btn = 1'b0; step(1);

    // Asynchronous reset mid-POINT with score1 = 3
    press();
    press();
    repeat (3) begin
      Ball_X = 16'd700; step(1);
      Ball_X = 16'd300;
      ticks(PAUSE);
      press();
    end
    Ball_X = 16'd0; step(1);
    Ball_X = 16'd300;
    ticks(10);
    chk("pre_rst_s1",    16'(score1), 16'd3);
    chk("pre_rst_state", 16'(game_state), 16'd3);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 chk_reset_vals("arst");
    step(1);
    reset = 1'b0;
    step(3);
    chk("post_rst_state", 16'(game_state), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
